// File: rtl/bfp_vect_unpack.sv
// Converts beats of P block-floating-point mantissas (one shared exponent per beat)
// back to IEEE-754 words and gathers V/P beats into one V-word vector behind a valid/ack handshake.
module bfp_vect_unpack #(
  parameter int V    = 8,
  parameter int P    = 4,
  parameter int BIT  = 32,
  parameter int FPM  = 23,
  parameter int BFPM = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     invals_rdy,
  input  logic [P*(BFPM+2)-1:0]    invals,
  input  logic [BIT-FPM-2:0]       inExp,
  output logic                     in_ready,
  output logic                     valid_out,
  output logic [V*BIT-1:0]         outvect,
  input  logic                     out_ack,
  output logic                     done
);

  localparam int E    = BIT - FPM - 1;
  localparam int LW   = BFPM + 2;
  localparam int NB   = V / P;
  localparam int CW   = (NB > 1) ? $clog2(NB) : 1;

  logic [CW-1:0]  beat_cnt;
  logic [BIT-1:0] conv [P];
  logic           accept;
  logic           last_beat;

  // One lane: normalise the magnitude so its leading one sits at bit BFPM,
  // then the bits below it become the fraction and the shift adjusts the exponent.
  function automatic logic [BIT-1:0] convert(input logic [LW-1:0] lane,
                                             input logic [E-1:0]  ex);
    logic                 s;
    logic [BFPM:0]        m;
    logic [BFPM:0]        norm;
    logic [FPM-1:0]       frac;
    logic signed [E+1:0]  e;
    logic [BIT-1:0]       res;
    int                   k;
    s    = lane[BFPM+1];
    m    = lane[BFPM:0];
    k    = 0;
    for (int j = 0; j <= BFPM; j++) begin
      if (m[j]) k = j;
    end
    e    = $signed({2'b00, ex}) - $signed((E+2)'(BFPM - k));
    norm = m << (BFPM - k);
    frac = '0;
    frac[FPM-1 -: BFPM] = norm[BFPM-1:0];
    if (m == '0) begin
      res = '0;
    end else if (ex == {E{1'b1}}) begin
      res = {s, {E{1'b1}}, {FPM{1'b0}}};
    end else if (e[E+1] || (e == '0)) begin
      res = {s, {(BIT-1){1'b0}}};
    end else begin
      res = {s, e[E-1:0], frac};
    end
    return res;
  endfunction

  // Lane 0 occupies the most significant slot of invals.
  always_comb begin
    for (int i = 0; i < P; i++) begin
      conv[i] = convert(invals[(P-1-i)*LW +: LW], inExp);
    end
  end

  assign in_ready  = !valid_out || out_ack;
  assign accept    = invals_rdy && in_ready;
  assign last_beat = (beat_cnt == CW'(NB - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt  <= '0;
      valid_out <= 1'b0;
      done      <= 1'b0;
      outvect   <= '0;
    end else begin
      done <= 1'b0;
      if (valid_out && out_ack) begin
        valid_out <= 1'b0;
      end
      if (accept) begin
        for (int i = 0; i < P; i++) begin
          outvect[(int'(beat_cnt) * P + i) * BIT +: BIT] <= conv[i];
        end
        if (last_beat) begin
          beat_cnt  <= '0;
          valid_out <= 1'b1;
          done      <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bfp_vect_unpack.sv
// Directed bench for bfp_vect_unpack (V=8, P=4, BFPM=4) with hand-computed FP32 results.
module tb_bfp_vect_unpack;

  logic         clk;
  logic         reset;
  logic         invals_rdy;
  logic [23:0]  invals;
  logic [7:0]   inExp;
  logic         in_ready;
  logic         valid_out;
  logic [255:0] outvect;
  logic         out_ack;
  logic         done;

  int checks;
  int failures;
  logic [31:0] expv [8];

  bfp_vect_unpack #(.V(8), .P(4), .BIT(32), .FPM(23), .BFPM(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .invals_rdy (invals_rdy),
    .invals     (invals),
    .inExp      (inExp),
    .in_ready   (in_ready),
    .valid_out  (valid_out),
    .outvect    (outvect),
    .out_ack    (out_ack),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one accepting beat and sample 1 time unit after the edge.
  task automatic beat(input logic [23:0] v, input logic [7:0] e, input logic ack);
    @(negedge clk);
    invals_rdy = 1'b1;
    invals     = v;
    inExp      = e;
    out_ack    = ack;
    @(posedge clk);
    #1;
    invals_rdy = 1'b0;
    out_ack    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; invals_rdy = 1'b0; invals = '0; inExp = '0; out_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b want=0", valid_out); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (outvect !== '0) begin failures++; $display("[TB] FAIL reset_outvect got=%h want=0", outvect); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_first_vector();
    beat({4{6'b011000}}, 8'd127, 1'b0);
    for (int i = 0; i < 8; i++) expv[i] = (i < 4) ? 32'h3FC00000 : 32'h0;
    checks++; if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL first_beat_valid got=%b want=0", valid_out); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL first_beat_done got=%b want=0", done); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (outvect[i*32 +: 32] !== expv[i]) begin failures++; $display("[TB] FAIL first_beat_word%0d got=%h want=%h", i, outvect[i*32 +: 32], expv[i]); end
    end
    beat({6'b010100, 6'b001100, 6'b111000, 6'b000000}, 8'd128, 1'b0);
    expv[4] = 32'h40200000; expv[5] = 32'h3FC00000; expv[6] = 32'hC0400000; expv[7] = 32'h00000000;
    checks++; if (valid_out !== 1'b1) begin failures++; $display("[TB] FAIL vec1_valid got=%b want=1", valid_out); end
    checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL vec1_done got=%b want=1", done); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (outvect[i*32 +: 32] !== expv[i]) begin failures++; $display("[TB] FAIL vec1_word%0d got=%h want=%h", i, outvect[i*32 +: 32], expv[i]); end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    invals_rdy = 1'b1; invals = {4{6'b011000}}; inExp = 8'd126; out_ack = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_in_ready c%0d got=%b want=0", c, in_ready); end
      checks++; if (valid_out !== 1'b1) begin failures++; $display("[TB] FAIL stall_valid c%0d got=%b want=1", c, valid_out); end
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL stall_done c%0d got=%b want=0", c, done); end
      for (int i = 0; i < 8; i++) begin
        checks++; if (outvect[i*32 +: 32] !== expv[i]) begin failures++; $display("[TB] FAIL stall_word%0d c%0d got=%h want=%h", i, c, outvect[i*32 +: 32], expv[i]); end
      end
    end
    beat({4{6'b011000}}, 8'd126, 1'b1);
    for (int i = 0; i < 4; i++) expv[i] = 32'h3F400000;
    checks++; if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL ack_valid got=%b want=0", valid_out); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL ack_in_ready got=%b want=1", in_ready); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (outvect[i*32 +: 32] !== expv[i]) begin failures++; $display("[TB] FAIL ack_word%0d got=%h want=%h", i, outvect[i*32 +: 32], expv[i]); end
    end
  endtask

  task automatic test_special();
    // Flush cases at inExp=1 complete the vector started in the stall test.
    beat({6'b000110, 6'b100110, 6'b010000, 6'b000001}, 8'd1, 1'b0);
    expv[4] = 32'h00000000; expv[5] = 32'h80000000; expv[6] = 32'h00800000; expv[7] = 32'h00000000;
    checks++; if (valid_out !== 1'b1) begin failures++; $display("[TB] FAIL flush_valid got=%b want=1", valid_out); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (outvect[i*32 +: 32] !== expv[i]) begin failures++; $display("[TB] FAIL flush_word%0d got=%h want=%h", i, outvect[i*32 +: 32], expv[i]); end
    end
    @(negedge clk); out_ack = 1'b1;
    @(posedge clk); #1; out_ack = 1'b0;
    checks++; if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL flush_ack_valid got=%b want=0", valid_out); end
    beat({6'b110000, 6'b010000, 6'b100000, 6'b001111}, 8'hFF, 1'b0);
    beat({6'b000001, 6'b011111, 6'b000011, 6'b100000}, 8'd130, 1'b0);
    expv[0] = 32'hFF800000; expv[1] = 32'h7F800000; expv[2] = 32'h00000000; expv[3] = 32'h7F800000;
    expv[4] = 32'h3F000000; expv[5] = 32'h41780000; expv[6] = 32'h3FC00000; expv[7] = 32'h00000000;
    checks++; if (valid_out !== 1'b1) begin failures++; $display("[TB] FAIL inf_valid got=%b want=1", valid_out); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (outvect[i*32 +: 32] !== expv[i]) begin failures++; $display("[TB] FAIL inf_word%0d got=%h want=%h", i, outvect[i*32 +: 32], expv[i]); end
    end
    @(negedge clk); out_ack = 1'b1;
    @(posedge clk); #1; out_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    beat({4{6'b011000}}, 8'd140, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (outvect !== '0) begin failures++; $display("[TB] FAIL midreset_outvect got=%h want=0", outvect); end
    checks++; if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL midreset_valid got=%b want=0", valid_out); end
    @(negedge clk);
    reset = 1'b0;
    beat({6'b010000, 6'b110000, 6'b011000, 6'b000000}, 8'd127, 1'b0);
    checks++; if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL postreset_beat1_valid got=%b want=0", valid_out); end
    beat({4{6'b010000}}, 8'd127, 1'b0);
    expv[0] = 32'h3F800000; expv[1] = 32'hBF800000; expv[2] = 32'h3FC00000; expv[3] = 32'h00000000;
    for (int i = 4; i < 8; i++) expv[i] = 32'h3F800000;
    checks++; if (valid_out !== 1'b1) begin failures++; $display("[TB] FAIL postreset_beat2_valid got=%b want=1", valid_out); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (outvect[i*32 +: 32] !== expv[i]) begin failures++; $display("[TB] FAIL postreset_word%0d got=%h want=%h", i, outvect[i*32 +: 32], expv[i]); end
    end
    @(negedge clk); out_ack = 1'b1;
    @(posedge clk); #1; out_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exps [4];
    logic       vexp [4];
    exps[0] = 8'd127; exps[1] = 8'd128; exps[2] = 8'd129; exps[3] = 8'd130;
    vexp[0] = 1'b0;   vexp[1] = 1'b1;   vexp[2] = 1'b0;   vexp[3] = 1'b1;
    @(negedge clk);
    invals_rdy = 1'b1; out_ack = 1'b1; invals = {4{6'b010000}};
    for (int b = 0; b < 4; b++) begin
      inExp = exps[b];
      @(posedge clk);
      #1;
      checks++; if (valid_out !== vexp[b]) begin failures++; $display("[TB] FAIL b2b_valid%0d got=%b want=%b", b, valid_out, vexp[b]); end
      checks++; if (done !== vexp[b]) begin failures++; $display("[TB] FAIL b2b_done%0d got=%b want=%b", b, done, vexp[b]); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_in_ready%0d got=%b want=1", b, in_ready); end
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) expv[i] = (i < 4) ? 32'h40800000 : 32'h41000000;
    for (int i = 0; i < 8; i++) begin
      checks++; if (outvect[i*32 +: 32] !== expv[i]) begin failures++; $display("[TB] FAIL b2b_word%0d got=%h want=%h", i, outvect[i*32 +: 32], expv[i]); end
    end
    invals_rdy = 1'b0;
    @(posedge clk); #1;
    out_ack = 1'b0;
    checks++; if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL b2b_final_ack_valid got=%b want=0", valid_out); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_first_vector();
    test_backpressure();
    test_special();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
